dcache_miss_ctrl: RTL and testbench
===================================

# dcache_miss_ctrl

Cache-stage miss controller for the data cache; it is the consumer side of the tag-lookup to cache pipeline register. It decodes the registered lookup result (miss, LRU way, buffer hit, kill), stalls the core, and runs the memory transaction. That transaction is an optional dirty-victim writeback followed by a line fill. It then hands the fill line to the data/tag arrays in a single update cycle.

## Interface
- ADDR_W, 20, byte address width (tag [19:6], index [5:4], offset [3:0])
- LINE_W, 128, line width in bits (4 x 32-bit words)
- clk_i  in  1  clock, rising edge
- rsn_i  in  1  asynchronous active-low reset
- kill_i  in  1  squash the access currently held in the cache-stage latch
- c_addr_i  in  ADDR_W  access address from the latch
- c_miss_i  in  1  tag lookup missed
- c_buffer_hit_i  in  1  store buffer services the access; no memory traffic
- c_lru_way_i  in  2  victim way
- c_lru_dirty_i  in  1  victim line dirty
- c_lru_tag_i  in  14  victim tag
- c_lru_line_i  in  LINE_W  victim line data
- stall_core_o  out  1  freeze the pipeline, including the cache-stage latch
- mem_rqst_o  out  1  memory request valid
- mem_we_o  out  1  1 = writeback, 0 = fill read
- mem_addr_o  out  ADDR_W  line-aligned address, [3:0] = 0
- mem_data_o  out  LINE_W  writeback data
- mem_ready_i  in  1  one-cycle completion pulse; carries read data on fills
- mem_data_i  in  LINE_W  fill data, valid when mem_ready_i
- fill_we_o  out  1  write the fill line, tag, valid=1 and dirty=0
- fill_way_o  out  2  way to write
- fill_index_o  out  2  set to write
- fill_tag_o  out  14  tag to write
- fill_data_o  out  LINE_W  line to write; also bypass data for the stalled access

## Operation
- States: IDLE, WB, FILL, UPDATE (2-bit encoding).
- The start condition is computed in IDLE only: start = c_miss_i & ~c_buffer_hit_i & ~kill_i.
- IDLE transitions:
  - start with c_lru_dirty_i = 1 goes to WB.
  - start with c_lru_dirty_i = 0 goes to FILL.
  - Otherwise the block stays in IDLE.
- On start, the block captures into registers: the address, victim way, victim tag, victim line and index. All later outputs come from these registers, not from the latch inputs.
- WB:
  - Outputs: mem_rqst_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 4'b0}, mem_data_o=victim line.
  - mem_ready_i moves the block to FILL.
- FILL:
  - Outputs: mem_rqst_o=1, mem_we_o=0, mem_addr_o={addr[19:4], 4'b0}.
  - mem_ready_i captures mem_data_i into the line register and moves the block to UPDATE.
- UPDATE:
  - fill_we_o=1 for exactly one cycle.
  - fill_way_o = captured LRU way; fill_index_o = addr[5:4]; fill_tag_o = addr[19:6]; fill_data_o = line register.
  - The next state is always IDLE.
- stall_core_o = start (in IDLE) | state == WB | state == FILL. It is low in UPDATE, so the latch advances at the end of UPDATE. The stalled access completes using fill_data_o as bypass, with word select outside this block. The stale miss is therefore never re-seen in IDLE.
- Request rules:
  - mem_rqst_o and all mem_* outputs stay stable from assertion until the cycle mem_ready_i is sampled high.
  - mem_ready_i is ignored in IDLE and UPDATE.
- kill_i affects only the start decision in IDLE. In WB or FILL it is ignored: the memory transaction always completes, and UPDATE still writes the line. The bypass result is discarded downstream.
- Reset (rsn_i low, asynchronous, at any time, including mid-WB or mid-FILL):
  - state goes to IDLE.
  - All outputs go to 0: stall_core_o, mem_rqst_o, mem_we_o, mem_addr_o, mem_data_o, fill_we_o, fill_way_o, fill_index_o, fill_tag_o, fill_data_o.
  - The capture registers go to 0.
  - The memory side must tolerate an abandoned request.

## Timing
- The miss is visible at cycle 0: stall_core_o=1 combinationally in cycle 0. The state is WB or FILL from cycle 1, and mem_rqst_o is registered-high from cycle 1.
- Clean miss with mem_ready_i in cycle k (k >= 1): UPDATE in cycle k+1 with fill_we_o=1 and stall_core_o=0. IDLE in cycle k+2.
- Dirty miss with writeback ready in cycle j and fill ready in cycle k > j: FILL in j+1 to k, UPDATE in k+1.
- Minimum miss penalty: clean 2 stall cycles; dirty 3 stall cycles (ready in the first request cycle each time).
- A new miss is accepted in the IDLE cycle immediately after UPDATE (back-to-back), with no bubble.
- mem_ready_i in the same cycle that mem_rqst_o first rises is legal and completes that phase.

## Test plan
- Clean load miss at 0x12340, way 2, ready 3 cycles after request: stall high 4 cycles; mem_addr_o=0x12340, mem_we_o=0; UPDATE with fill_way_o=2, fill_index_o=0, fill_tag_o=0x048D, fill_data_o = returned line.
- Dirty miss, victim tag 0x0011, index 1: WB request at addr 0x00450 with mem_we_o=1 and victim data; then FILL request; one fill_we_o pulse; stall drops in UPDATE.
- Held inputs: c_miss_i=1 with c_buffer_hit_i=1, or with kill_i=1, in IDLE: no stall, no mem_rqst_o, state stays IDLE.
- kill_i pulsed during FILL: the request is held until ready, UPDATE still occurs, fill_we_o=1 once.
- rsn_i low mid-FILL, then high: all outputs 0 immediately; IDLE; a late mem_ready_i is ignored; the next miss proceeds normally.
- Two consecutive misses (0x00100 then 0x00200), ready=1 immediately each: two UPDATE pulses separated by exactly one request cycle, with correct addresses.

Source files
------------

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: decodes the registered lookup result, stalls the core,
// runs an optional dirty-victim writeback plus a line fill, then writes the line back in one cycle.
module dcache_miss_ctrl #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic              c_miss_i,
  input  logic              c_buffer_hit_i,
  input  logic [1:0]        c_lru_way_i,
  input  logic              c_lru_dirty_i,
  input  logic [ADDR_W-7:0] c_lru_tag_i,
  input  logic [LINE_W-1:0] c_lru_line_i,
  output logic              stall_core_o,
  output logic              mem_rqst_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              fill_we_o,
  output logic [1:0]        fill_way_o,
  output logic [1:0]        fill_index_o,
  output logic [ADDR_W-7:0] fill_tag_o,
  output logic [LINE_W-1:0] fill_data_o
);

  localparam int TAG_W = ADDR_W - 6;

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2, UPDATE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-5:0]  line_addr_q, line_addr_d;   // address without the byte offset
  logic [1:0]         way_q, way_d;
  logic [TAG_W-1:0]   vtag_q, vtag_d;
  logic [LINE_W-1:0]  line_q, line_d;             // victim line, then overwritten by fill data
  logic               start;
  logic               unused_offset;

  assign unused_offset = ^c_addr_i[3:0];

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      way_q       <= '0;
      vtag_q      <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      way_q       <= way_d;
      vtag_q      <= vtag_d;
      line_q      <= line_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    way_d        = way_q;
    vtag_d       = vtag_q;
    line_d       = line_q;
    start        = 1'b0;
    mem_rqst_o   = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    fill_we_o    = 1'b0;
    fill_way_o   = '0;
    fill_index_o = '0;
    fill_tag_o   = '0;
    fill_data_o  = '0;
    case (state_q)
      IDLE: begin
        start = c_miss_i & ~c_buffer_hit_i & ~kill_i;
        if (start) begin
          line_addr_d = c_addr_i[ADDR_W-1:4];
          way_d       = c_lru_way_i;
          vtag_d      = c_lru_tag_i;
          line_d      = c_lru_line_i;
          state_d     = c_lru_dirty_i ? WB : FILL;
        end
      end
      WB: begin
        mem_rqst_o = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {vtag_q, line_addr_q[1:0], 4'b0000};
        mem_data_o = line_q;
        if (mem_ready_i) state_d = FILL;
      end
      FILL: begin
        mem_rqst_o = 1'b1;
        mem_addr_o = {line_addr_q, 4'b0000};
        if (mem_ready_i) begin
          line_d  = mem_data_i;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        fill_we_o    = 1'b1;
        fill_way_o   = way_q;
        fill_index_o = line_addr_q[1:0];
        fill_tag_o   = line_addr_q[ADDR_W-5:2];
        fill_data_o  = line_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so a held miss cannot raise the stall while the block is reset.
  assign stall_core_o = (start & rsn_i) | (state_q == WB) | (state_q == FILL);

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Self-checking bench for dcache_miss_ctrl: start-decision table, directed miss sequences,
// reset mid-fill, and randomized transactions checked against a transaction-level model.
module tb_dcache_miss_ctrl;

  logic         clk_i = 1'b0;
  logic         rsn_i = 1'b0;
  logic         kill_i = 1'b0;
  logic [19:0]  c_addr_i = '0;
  logic         c_miss_i = 1'b0;
  logic         c_buffer_hit_i = 1'b0;
  logic [1:0]   c_lru_way_i = '0;
  logic         c_lru_dirty_i = 1'b0;
  logic [13:0]  c_lru_tag_i = '0;
  logic [127:0] c_lru_line_i = '0;
  logic         stall_core_o, mem_rqst_o, mem_we_o;
  logic [19:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic         mem_ready_i = 1'b0;
  logic [127:0] mem_data_i = '0;
  logic         fill_we_o;
  logic [1:0]   fill_way_o, fill_index_o;
  logic [13:0]  fill_tag_o;
  logic [127:0] fill_data_o;

  int tests = 0;
  int fails = 0;

  dcache_miss_ctrl #(.ADDR_W(20), .LINE_W(128)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .kill_i(kill_i), .c_addr_i(c_addr_i),
    .c_miss_i(c_miss_i), .c_buffer_hit_i(c_buffer_hit_i), .c_lru_way_i(c_lru_way_i),
    .c_lru_dirty_i(c_lru_dirty_i), .c_lru_tag_i(c_lru_tag_i), .c_lru_line_i(c_lru_line_i),
    .stall_core_o(stall_core_o), .mem_rqst_o(mem_rqst_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
    .mem_data_i(mem_data_i), .fill_we_o(fill_we_o), .fill_way_o(fill_way_o),
    .fill_index_o(fill_index_o), .fill_tag_o(fill_tag_o), .fill_data_o(fill_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic miss, bhit, kill, dirty;
    logic exp_stall, exp_rqst, exp_we;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, "_stall"}, stall_core_o, 0);
    chk({name, "_rqst"}, mem_rqst_o, 0);
    chk({name, "_bus"}, {mem_we_o, mem_addr_o, fill_we_o, fill_way_o, fill_index_o, fill_tag_o}, 0);
    chk({name, "_mdata"}, mem_data_o, 0);
    chk({name, "_fdata"}, fill_data_o, 0);
  endtask

  // One complete miss starting in an IDLE cycle; ends just after the UPDATE cycle's edge.
  // wbd/fd: number of wait cycles before mem_ready_i in the writeback/fill phases.
  task automatic do_miss(input logic [19:0] addr, input logic [1:0] way, input logic dirty,
                         input logic [13:0] vtag, input logic [127:0] vline,
                         input logic [127:0] fdata, input int wbd, input int fd,
                         input logic kill_in_fill);
    int stalls = 0;
    logic [19:0] wb_addr   = {vtag, addr[5:4], 4'b0000};
    logic [19:0] fill_addr = {addr[19:4], 4'b0000};
    c_addr_i = addr; c_lru_way_i = way; c_lru_dirty_i = dirty; c_lru_tag_i = vtag;
    c_lru_line_i = vline; c_miss_i = 1; c_buffer_hit_i = 0; kill_i = 0; mem_ready_i = 0;
    #1;
    chk("c0_stall", stall_core_o, 1);
    chk("c0_rqst", mem_rqst_o, 0);
    chk("c0_fill_we", fill_we_o, 0);
    if (stall_core_o === 1'b1) stalls++;
    tick();
    // Later outputs must come from captured values, not from the latch inputs.
    c_addr_i = 20'($urandom); c_lru_way_i = 2'($urandom); c_lru_tag_i = 14'($urandom);
    c_lru_line_i = rnd_line();
    if (dirty) begin
      for (int i = 0; i <= wbd; i++) begin
        chk("wb_rqst", {mem_rqst_o, mem_we_o}, 2'b11);
        chk("wb_addr", mem_addr_o, wb_addr);
        chk("wb_data", mem_data_o, vline);
        if (stall_core_o === 1'b1) stalls++;
        mem_ready_i = (i == wbd);
        mem_data_i = rnd_line();
        tick();
        mem_ready_i = 0;
      end
    end
    for (int i = 0; i <= fd; i++) begin
      chk("fill_rqst", {mem_rqst_o, mem_we_o}, 2'b10);
      chk("fill_addr", mem_addr_o, fill_addr);
      chk("fill_no_we", fill_we_o, 0);
      if (stall_core_o === 1'b1) stalls++;
      kill_i = kill_in_fill && (i == 0);
      mem_ready_i = (i == fd);
      mem_data_i = (i == fd) ? fdata : rnd_line();
      tick();
      mem_ready_i = 0;
      kill_i = 0;
    end
    chk("upd_we", fill_we_o, 1);
    chk("upd_stall_rqst", {stall_core_o, mem_rqst_o}, 2'b00);
    chk("upd_way_idx_tag", {fill_way_o, fill_index_o, fill_tag_o}, {way, addr[5:4], addr[19:6]});
    chk("upd_data", fill_data_o, fdata);
    chk("stall_cycles", stalls, 1 + (dirty ? wbd + 1 : 0) + fd + 1);
    $display("[TB] miss addr=%h dirty=%0d wbd=%0d fd=%0d kill=%0d stalls=%0d", addr, dirty, wbd,
             fd, kill_in_fill, stalls);
    mem_ready_i = $urandom_range(0, 1);   // ignored in UPDATE
    mem_data_i = rnd_line();
    tick();
    mem_ready_i = 0;
    c_miss_i = 0;
  endtask

  // One IDLE cycle with a stray ready pulse that must not do anything.
  task automatic idle_check(input string name);
    c_miss_i = 0; kill_i = 0; mem_ready_i = 1;
    #1;
    chk({name, "_idle"}, {stall_core_o, mem_rqst_o, fill_we_o}, 3'b000);
    tick();
    mem_ready_i = 0;
    #1;
    chk({name, "_after"}, {stall_core_o, mem_rqst_o, fill_we_o}, 3'b000);
  endtask

  task automatic finish_txn();
    int n = 0;
    while (fill_we_o !== 1'b1 && n < 20) begin
      mem_ready_i = mem_rqst_o;
      tick();
      mem_ready_i = 0;
      #1;
      n++;
    end
    chk("txn_done", fill_we_o, 1);
    tick();
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 1, 1, 0};
    vecs[2] = '{1, 0, 0, 1, 1, 1, 1};
    vecs[3] = '{1, 1, 0, 0, 0, 0, 0};
    vecs[4] = '{1, 0, 1, 0, 0, 0, 0};
    vecs[5] = '{1, 1, 1, 1, 0, 0, 0};
    vecs[6] = '{0, 0, 1, 1, 0, 0, 0};
    vecs[7] = '{1, 1, 0, 1, 0, 0, 0};

    // Reset with a miss held on the latch
    c_miss_i = 1;
    #3;
    chk_all_zero("reset");
    tick();
    rsn_i = 1;
    c_miss_i = 0;
    tick();

    // Start-decision table
    for (int v = 0; v < 8; v++) begin
      c_miss_i = vecs[v].miss; c_buffer_hit_i = vecs[v].bhit; kill_i = vecs[v].kill;
      c_lru_dirty_i = vecs[v].dirty; c_addr_i = 20'($urandom); c_lru_tag_i = 14'($urandom);
      #1;
      chk("tbl_stall", stall_core_o, vecs[v].exp_stall);
      tick();
      c_miss_i = 0; c_buffer_hit_i = 0; kill_i = 0;
      #1;
      chk("tbl_rqst_we", {mem_rqst_o, mem_we_o}, {vecs[v].exp_rqst, vecs[v].exp_we});
      $display("[TB] vec %0d miss=%0d bhit=%0d kill=%0d dirty=%0d stall=%0d rqst=%0d", v,
               vecs[v].miss, vecs[v].bhit, vecs[v].kill, vecs[v].dirty, vecs[v].exp_stall,
               vecs[v].exp_rqst);
      if (vecs[v].exp_stall) finish_txn();
      else tick();
    end

    // Clean miss at 0x12340, ready in the third request cycle
    do_miss(20'h12340, 2'd2, 0, 14'h0, rnd_line(), 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
            0, 2, 0);
    idle_check("clean");
    // Dirty miss, victim tag 0x0011, index 1
    do_miss(20'h05A50, 2'd1, 1, 14'h0011, rnd_line(), rnd_line(), 1, 1, 0);
    idle_check("dirty");
    // kill pulsed during FILL
    do_miss(20'h0ABC0, 2'd3, 0, 14'h0, rnd_line(), rnd_line(), 0, 3, 1);
    idle_check("kill");

    // Reset mid-FILL, then a late ready
    c_addr_i = 20'h33330; c_lru_dirty_i = 0; c_miss_i = 1; c_buffer_hit_i = 0;
    tick();
    chk("rst_fill_rqst", mem_rqst_o, 1);
    #1;
    rsn_i = 0;
    #1;
    chk_all_zero("rst_mid");
    c_miss_i = 0;
    tick();
    rsn_i = 1;
    mem_ready_i = 1;
    tick();
    mem_ready_i = 0;
    #1;
    chk("rst_late_ready", {stall_core_o, mem_rqst_o, fill_we_o}, 3'b000);
    $display("[TB] reset mid-fill done");
    do_miss(20'h44440, 2'd0, 1, 14'h1234, rnd_line(), rnd_line(), 0, 0, 0);

    // Back-to-back misses, immediate ready
    do_miss(20'h00100, 2'd1, 0, 14'h0, rnd_line(), rnd_line(), 0, 0, 0);
    do_miss(20'h00200, 2'd2, 0, 14'h0, rnd_line(), rnd_line(), 0, 0, 0);
    idle_check("b2b");

    // Randomized transactions
    for (int r = 0; r < 40; r++) begin
      do_miss(20'($urandom), 2'($urandom), 1'($urandom), 14'($urandom), rnd_line(), rnd_line(),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_check("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
